// File: rtl/ctrl_pipe_unit.sv
// Pipelined control decoder: opcode decode, ID/EX and EX/MEM control registers,
// compare flag, branch-on-true flush, load-use interlock and event counters.
module ctrl_pipe_unit #(
    parameter int REG_AW         = 4,
    parameter int CMP_W          = 2,
    parameter int CNT_W          = 16,
    parameter int LOAD_INTERLOCK = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           opcode,
    input  logic [CMP_W-1:0]     cmp_mode,
    input  logic [REG_AW-1:0]    rs_a,
    input  logic [REG_AW-1:0]    rs_b,
    input  logic [REG_AW-1:0]    rd,
    input  logic                 mem_busy,
    input  logic                 cmp_result,
    output logic                 ex_valid,
    output logic [4+CMP_W-1:0]   ex_alu_control,
    output logic [1:0]           ex_sel_b,
    output logic                 ex_alu_mux,
    output logic                 ex_cmp_en,
    output logic [REG_AW-1:0]    ex_rd,
    output logic                 mem_valid,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic                 mem_sel_data_out,
    output logic                 mem_reg_we,
    output logic [REG_AW-1:0]    mem_rd,
    output logic                 flag_q,
    output logic                 branch_taken,
    output logic                 stall,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int CTL_W = 4 + CMP_W;

    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_CMP = 4'h8;
    localparam logic [3:0] OP_MOV = 4'hB;
    localparam logic [3:0] OP_LD  = 4'hC;
    localparam logic [3:0] OP_ST  = 4'hD;
    localparam logic [3:0] OP_BT  = 4'hE;
    localparam logic [3:0] OP_NOP = 4'hF;

    logic       d_re_a, d_re_b, d_reg_we, d_mem_we, d_mem_re, d_sdo;
    logic       d_alu_mux, d_cmp_en;
    logic [1:0] d_sel_b;

    always_comb begin
        d_re_a    = 1'b1;
        d_re_b    = 1'b1;
        d_reg_we  = 1'b1;
        d_mem_we  = 1'b0;
        d_mem_re  = 1'b0;
        d_sdo     = 1'b0;
        d_alu_mux = 1'b0;
        d_cmp_en  = 1'b0;
        d_sel_b   = 2'd0;
        case (opcode)
            OP_NOT: d_re_b = 1'b0;
            OP_CMP: begin
                d_reg_we = 1'b0;
                d_cmp_en = 1'b1;
            end
            OP_MOV: begin
                d_re_a    = 1'b0;
                d_re_b    = 1'b0;
                d_alu_mux = 1'b1;
            end
            OP_LD: begin
                d_re_b   = 1'b0;
                d_mem_re = 1'b1;
                d_sdo    = 1'b1;
                d_sel_b  = 2'd1;
            end
            OP_ST: begin
                d_reg_we = 1'b0;
                d_mem_we = 1'b1;
                d_sel_b  = 2'd2;
            end
            OP_BT, OP_NOP: begin
                d_re_a   = 1'b0;
                d_re_b   = 1'b0;
                d_reg_we = 1'b0;
            end
            default: ;
        endcase
    end

    // Control bits that only matter downstream of EX are kept internally.
    logic ex_mem_we, ex_mem_re, ex_sdo, ex_reg_we;
    logic [3:0] ex_op;
    logic ex_is_ld, ex_is_bt, branch_now, hazard_raw, hazard, take;

    assign ex_op    = ex_alu_control[CTL_W-1 -: 4];
    assign ex_is_ld = ex_valid & (ex_op == OP_LD);
    assign ex_is_bt = ex_valid & (ex_op == OP_BT);

    assign hazard_raw = in_valid & ex_is_ld & (ex_rd != '0) &
                        ((d_re_a & (rs_a == ex_rd)) | (d_re_b & (rs_b == ex_rd)));
    assign hazard     = (LOAD_INTERLOCK != 0) & hazard_raw;
    assign branch_now = ex_is_bt & flag_q;

    assign in_ready     = ~mem_busy & ~hazard & ~branch_now;
    assign branch_taken = ~mem_busy & branch_now;
    assign stall        = ~mem_busy & ~branch_now & hazard;
    assign take         = in_ready & in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid         <= 1'b0;
            ex_alu_control   <= '0;
            ex_sel_b         <= 2'd0;
            ex_alu_mux       <= 1'b0;
            ex_cmp_en        <= 1'b0;
            ex_rd            <= '0;
            ex_mem_we        <= 1'b0;
            ex_mem_re        <= 1'b0;
            ex_sdo           <= 1'b0;
            ex_reg_we        <= 1'b0;
            mem_valid        <= 1'b0;
            mem_we           <= 1'b0;
            mem_re           <= 1'b0;
            mem_sel_data_out <= 1'b0;
            mem_reg_we       <= 1'b0;
            mem_rd           <= '0;
            flag_q           <= 1'b0;
        end else if (!mem_busy) begin
            if (take) begin
                ex_valid       <= 1'b1;
                ex_alu_control <= {opcode, cmp_mode};
                ex_sel_b       <= d_sel_b;
                ex_alu_mux     <= d_alu_mux;
                ex_cmp_en      <= d_cmp_en;
                ex_rd          <= rd;
                ex_mem_we      <= d_mem_we;
                ex_mem_re      <= d_mem_re;
                ex_sdo         <= d_sdo;
                ex_reg_we      <= d_reg_we;
            end else begin
                ex_valid       <= 1'b0;
                ex_alu_control <= '0;
                ex_sel_b       <= 2'd0;
                ex_alu_mux     <= 1'b0;
                ex_cmp_en      <= 1'b0;
                ex_rd          <= '0;
                ex_mem_we      <= 1'b0;
                ex_mem_re      <= 1'b0;
                ex_sdo         <= 1'b0;
                ex_reg_we      <= 1'b0;
            end
            mem_valid        <= ex_valid;
            mem_we           <= ex_valid & ex_mem_we;
            mem_re           <= ex_valid & ex_mem_re;
            mem_sel_data_out <= ex_valid & ex_sdo;
            mem_reg_we       <= ex_valid & ex_reg_we;
            mem_rd           <= ex_valid ? ex_rd : '0;
            if (ex_valid && ex_cmp_en) begin
                flag_q <= cmp_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (branch_taken && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit: decode table sweep, scoreboarded
// EX/MEM stage, hand sequences for interlock, branch flush, hold and saturation.
module tb_ctrl_pipe_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, mem_busy = 1'b0, cmp_result = 1'b0;
    logic [3:0] opcode = 4'h0, rs_a = 4'h0, rs_b = 4'h0, rd = 4'h0;
    logic [1:0] cmp_mode = 2'd0;

    logic       in_ready, ex_valid, ex_alu_mux, ex_cmp_en, mem_valid, mem_we, mem_re;
    logic       mem_sel_data_out, mem_reg_we, flag_q, branch_taken, stall;
    logic [5:0] ex_alu_control;
    logic [1:0] ex_sel_b;
    logic [3:0] ex_rd, mem_rd;
    logic [15:0] stall_cnt, flush_cnt;

    logic       in_ready_nl, ex_valid_nl, ex_alu_mux_nl, ex_cmp_en_nl, mem_valid_nl, mem_we_nl;
    logic       mem_re_nl, mem_sdo_nl, mem_reg_we_nl, flag_q_nl, branch_taken_nl, stall_nl;
    logic [5:0] ex_alu_control_nl;
    logic [1:0] ex_sel_b_nl;
    logic [3:0] ex_rd_nl, mem_rd_nl;
    logic [15:0] stall_cnt_nl, flush_cnt_nl;

    logic       in_ready_st, ex_valid_st, ex_alu_mux_st, ex_cmp_en_st, mem_valid_st, mem_we_st;
    logic       mem_re_st, mem_sdo_st, mem_reg_we_st, flag_q_st, branch_taken_st, stall_st;
    logic [5:0] ex_alu_control_st;
    logic [1:0] ex_sel_b_st;
    logic [3:0] ex_rd_st, mem_rd_st;
    logic [1:0] stall_cnt_st, flush_cnt_st;

    ctrl_pipe_unit u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .cmp_mode(cmp_mode), .rs_a(rs_a), .rs_b(rs_b), .rd(rd),
        .mem_busy(mem_busy), .cmp_result(cmp_result), .ex_valid(ex_valid),
        .ex_alu_control(ex_alu_control), .ex_sel_b(ex_sel_b), .ex_alu_mux(ex_alu_mux),
        .ex_cmp_en(ex_cmp_en), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_re(mem_re), .mem_sel_data_out(mem_sel_data_out), .mem_reg_we(mem_reg_we),
        .mem_rd(mem_rd), .flag_q(flag_q), .branch_taken(branch_taken), .stall(stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipe_unit #(.LOAD_INTERLOCK(0)) u_nl (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nl),
        .opcode(opcode), .cmp_mode(cmp_mode), .rs_a(rs_a), .rs_b(rs_b), .rd(rd),
        .mem_busy(mem_busy), .cmp_result(cmp_result), .ex_valid(ex_valid_nl),
        .ex_alu_control(ex_alu_control_nl), .ex_sel_b(ex_sel_b_nl), .ex_alu_mux(ex_alu_mux_nl),
        .ex_cmp_en(ex_cmp_en_nl), .ex_rd(ex_rd_nl), .mem_valid(mem_valid_nl), .mem_we(mem_we_nl),
        .mem_re(mem_re_nl), .mem_sel_data_out(mem_sdo_nl), .mem_reg_we(mem_reg_we_nl),
        .mem_rd(mem_rd_nl), .flag_q(flag_q_nl), .branch_taken(branch_taken_nl), .stall(stall_nl),
        .stall_cnt(stall_cnt_nl), .flush_cnt(flush_cnt_nl)
    );

    ctrl_pipe_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_st),
        .opcode(opcode), .cmp_mode(cmp_mode), .rs_a(rs_a), .rs_b(rs_b), .rd(rd),
        .mem_busy(mem_busy), .cmp_result(cmp_result), .ex_valid(ex_valid_st),
        .ex_alu_control(ex_alu_control_st), .ex_sel_b(ex_sel_b_st), .ex_alu_mux(ex_alu_mux_st),
        .ex_cmp_en(ex_cmp_en_st), .ex_rd(ex_rd_st), .mem_valid(mem_valid_st), .mem_we(mem_we_st),
        .mem_re(mem_re_st), .mem_sel_data_out(mem_sdo_st), .mem_reg_we(mem_reg_we_st),
        .mem_rd(mem_rd_st), .flag_q(flag_q_st), .branch_taken(branch_taken_st), .stall(stall_st),
        .stall_cnt(stall_cnt_st), .flush_cnt(flush_cnt_st)
    );

    typedef struct {
        logic [3:0] op;
        logic [1:0] sel_b;
        logic       alu_mux, cmp_en, mem_we, mem_re, sdo, reg_we;
    } dec_vec_t;

    typedef struct {
        logic [3:0] rd;
        logic       mem_we, mem_re, sdo, reg_we;
    } sb_t;

    dec_vec_t vec [16];
    sb_t      sb_q [$];
    int       n_tests = 0;
    int       n_fail  = 0;
    logic     last_ready, last_stall, last_bt, last_nl_ready, last_nl_stall;
    logic     acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one instruction for one cycle; push to the scoreboard if accepted.
    task automatic issue(input logic [3:0] op, input logic [1:0] cm, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] d, output logic ok);
        sb_t e;
        in_valid = 1'b1; opcode = op; cmp_mode = cm; rs_a = a; rs_b = b; rd = d;
        @(negedge clk);
        last_ready = in_ready; last_stall = stall; last_bt = branch_taken;
        last_nl_ready = in_ready_nl; last_nl_stall = stall_nl;
        ok = in_ready;
        if (ok) begin
            e.rd = d; e.mem_we = vec[op].mem_we; e.mem_re = vec[op].mem_re;
            e.sdo = vec[op].sdo; e.reg_we = vec[op].reg_we;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (ok)
            chk("ex_stage", {ex_valid, ex_alu_control, ex_sel_b, ex_alu_mux, ex_cmp_en, ex_rd},
                {1'b1, op, cm, vec[op].sel_b, vec[op].alu_mux, vec[op].cmp_en, d});
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0; mem_busy = 1'b0; cmp_result = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #2;
        sb_q.delete();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: an EX entry that moves on an edge must appear in MEM.
    logic ex_moving_s = 1'b0, busy_s = 1'b0;
    always @(negedge clk) begin
        ex_moving_s = ex_valid & ~mem_busy;
        busy_s = mem_busy;
    end

    always @(posedge clk) begin
        sb_t e;
        #1;
        if (rst_n) begin
            if (ex_moving_s) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_underflow: mem entry with no expected record at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("mem_stage", {mem_valid, mem_we, mem_re, mem_sel_data_out, mem_reg_we, mem_rd},
                        {1'b1, e.mem_we, e.mem_re, e.sdo, e.reg_we, e.rd});
                end
            end else if (!busy_s) begin
                chk("mem_bubble", {mem_valid, mem_we, mem_re, mem_reg_we, mem_rd}, 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op     sel  mux cmp we re sdo rwe
        vec[0]  = '{4'h0, 2'd0, 0, 0, 0, 0, 0, 1};
        vec[1]  = '{4'h1, 2'd0, 0, 0, 0, 0, 0, 1};
        vec[2]  = '{4'h2, 2'd0, 0, 0, 0, 0, 0, 1};
        vec[3]  = '{4'h3, 2'd0, 0, 0, 0, 0, 0, 1};
        vec[4]  = '{4'h4, 2'd0, 0, 0, 0, 0, 0, 1};
        vec[5]  = '{4'h5, 2'd0, 0, 0, 0, 0, 0, 1};
        vec[6]  = '{4'h6, 2'd0, 0, 0, 0, 0, 0, 1};
        vec[7]  = '{4'h7, 2'd0, 0, 0, 0, 0, 0, 1};
        vec[8]  = '{4'h8, 2'd0, 0, 1, 0, 0, 0, 0};
        vec[9]  = '{4'h9, 2'd0, 0, 0, 0, 0, 0, 1};
        vec[10] = '{4'hA, 2'd0, 0, 0, 0, 0, 0, 1};
        vec[11] = '{4'hB, 2'd0, 1, 0, 0, 0, 0, 1};
        vec[12] = '{4'hC, 2'd1, 0, 0, 0, 1, 1, 1};
        vec[13] = '{4'hD, 2'd2, 0, 0, 1, 0, 0, 0};
        vec[14] = '{4'hE, 2'd0, 0, 0, 0, 0, 0, 0};
        vec[15] = '{4'hF, 2'd0, 0, 0, 0, 0, 0, 0};

        // Reset state
        #12;
        chk("reset_state", {ex_valid, mem_valid, flag_q, branch_taken, stall, in_ready}, 6'b000001);
        chk("reset_cnt", {stall_cnt, flush_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Decode sweep, back to back
        for (int i = 0; i < 16; i++) begin
            issue(vec[i].op, 2'd2, 4'd1, 4'd1, 4'd5, acc);
            chk("sweep_accept", acc, 1);
        end
        idle(3);
        chk("sweep_drain", sb_q.size(), 0);
        chk("sweep_flag", {flag_q, flush_cnt}, 0);

        // Load-use on rs_a
        do_reset();
        issue(4'hC, 2'd0, 4'd1, 4'd1, 4'd3, acc);
        issue(4'h0, 2'd0, 4'd3, 4'd1, 4'd4, acc);
        chk("lu_refuse", {acc, last_stall}, 2'b01);
        chk("lu_nointerlock", {last_nl_ready, last_nl_stall}, 2'b10);
        chk("lu_bubble", {ex_valid, stall_cnt}, {1'b0, 16'd1});
        issue(4'h0, 2'd0, 4'd3, 4'd1, 4'd4, acc);
        chk("lu_accept", {acc, last_stall}, 2'b10);
        // Load-use on rs_b
        issue(4'hC, 2'd0, 4'd1, 4'd1, 4'd5, acc);
        issue(4'h1, 2'd0, 4'd1, 4'd5, 4'd6, acc);
        chk("lu_rsb_refuse", {acc, last_stall}, 2'b01);
        issue(4'h1, 2'd0, 4'd1, 4'd5, 4'd6, acc);
        chk("lu_rsb_accept", acc, 1);
        // Register 0, NOT (no rs_b read), MOV (no rs_a read): never stall
        issue(4'hC, 2'd0, 4'd1, 4'd1, 4'd0, acc);
        issue(4'h0, 2'd0, 4'd0, 4'd0, 4'd7, acc);
        chk("lu_r0", {acc, last_stall}, 2'b10);
        issue(4'hC, 2'd0, 4'd1, 4'd1, 4'd6, acc);
        issue(4'h6, 2'd0, 4'd1, 4'd6, 4'd7, acc);
        chk("lu_not_rsb", {acc, last_stall}, 2'b10);
        issue(4'hC, 2'd0, 4'd1, 4'd1, 4'd6, acc);
        issue(4'hB, 2'd0, 4'd6, 4'd1, 4'd7, acc);
        chk("lu_mov_rsa", {acc, last_stall}, 2'b10);
        idle(2);
        chk("lu_stall_cnt", stall_cnt, 2);
        chk("lu_drain", sb_q.size(), 0);

        // Branch taken: CMP(true), BT, ADD dropped
        do_reset();
        cmp_result = 1'b1;
        issue(4'h8, 2'd1, 4'd1, 4'd2, 4'd0, acc);
        issue(4'hE, 2'd0, 4'd0, 4'd0, 4'd0, acc);
        chk("br_flag_set", flag_q, 1);
        issue(4'h0, 2'd0, 4'd1, 4'd2, 4'd3, acc);
        chk("br_taken", {acc, last_bt}, 2'b01);
        chk("br_flush", {ex_valid, flush_cnt}, {1'b0, 16'd1});
        @(negedge clk);
        chk("br_pulse_once", {branch_taken, in_ready}, 2'b01);
        @(posedge clk); #1;
        chk("br_add_dropped", {ex_valid, flag_q, flush_cnt}, {1'b0, 1'b1, 16'd1});
        idle(1);
        chk("br_drain", sb_q.size(), 0);

        // Branch not taken
        do_reset();
        cmp_result = 1'b0;
        issue(4'h8, 2'd1, 4'd1, 4'd2, 4'd0, acc);
        issue(4'hE, 2'd0, 4'd0, 4'd0, 4'd0, acc);
        issue(4'h0, 2'd0, 4'd1, 4'd2, 4'd3, acc);
        chk("nbr_proceed", {acc, last_bt}, 2'b10);
        chk("nbr_state", {flag_q, flush_cnt}, 0);
        idle(2);

        // mem_busy during a load-use hazard
        do_reset();
        issue(4'h0, 2'd0, 4'd1, 4'd1, 4'd7, acc);
        issue(4'hC, 2'd0, 4'd1, 4'd1, 4'd3, acc);
        in_valid = 1'b1; opcode = 4'h0; cmp_mode = 2'd0; rs_a = 4'd3; rs_b = 4'd1; rd = 4'd4;
        mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("busy_comb", {in_ready, stall, branch_taken}, 0);
            @(posedge clk); #1;
            chk("busy_hold", {ex_valid, ex_rd, mem_valid, mem_rd, mem_reg_we, stall_cnt},
                {1'b1, 4'd3, 1'b1, 4'd7, 1'b1, 16'd0});
        end
        mem_busy = 1'b0;
        issue(4'h0, 2'd0, 4'd3, 4'd1, 4'd4, acc);
        chk("busy_release_stall", {acc, last_stall, stall_cnt}, {2'b01, 16'd1});
        issue(4'h0, 2'd0, 4'd3, 4'd1, 4'd4, acc);
        chk("busy_release_accept", acc, 1);
        idle(2);
        chk("busy_drain", sb_q.size(), 0);

        // Counter saturation on the 2-bit instance
        do_reset();
        for (int k = 0; k < 5; k++) begin
            issue(4'hC, 2'd0, 4'd1, 4'd1, 4'd3, acc);
            issue(4'h0, 2'd0, 4'd3, 4'd1, 4'd4, acc);
            issue(4'h0, 2'd0, 4'd3, 4'd1, 4'd4, acc);
        end
        chk("sat_main", stall_cnt, 5);
        chk("sat_2bit", stall_cnt_st, 3);
        idle(2);

        // Asynchronous reset mid-stream with live state
        cmp_result = 1'b1;
        issue(4'h8, 2'd3, 4'd1, 4'd2, 4'd0, acc);
        issue(4'h0, 2'd0, 4'd1, 4'd2, 4'd9, acc);
        chk("pre_reset", {ex_valid, mem_valid, flag_q}, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_state", {ex_valid, mem_valid, flag_q, branch_taken, stall}, 0);
        chk("midreset_cnt", {stall_cnt, flush_cnt}, 0);
        sb_q.delete();
        rst_n = 1'b1;
        cmp_result = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
